// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the cpu MEM stage and a debug/loader port, one access at a time.
// Defining DMEM_ARB_PERF_EN adds the stall_cycles and dbg_grants counters.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,
    output logic              dbg_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       dbg_grants
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t      state_reg;
    logic        owner_reg;       // 0 = cpu, 1 = dbg
    logic [3:0]  wait_cnt_reg;
    logic [7:0]  starve_cnt_reg;

    logic any_req;
    logic dbg_win;
    logic last_wait;

    assign any_req   = cpu_req | dbg_req;
    assign dbg_win   = dbg_req & (~cpu_req | (starve_cnt_reg == STARVE_LIM));
    assign last_wait = (state_reg == S_WAIT) && (wait_cnt_reg == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            owner_reg      <= 1'b0;
            wait_cnt_reg   <= 4'd0;
            starve_cnt_reg <= 8'd0;
            mem_en         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            busy           <= 1'b0;
            dbg_gnt        <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // Reaching here with dbg_req high and dbg losing means cpu was granted.
                    if (dbg_win || !dbg_req) begin
                        starve_cnt_reg <= 8'd0;
                    end else if (starve_cnt_reg != STARVE_LIM) begin
                        starve_cnt_reg <= starve_cnt_reg + 8'd1;
                    end
                    if (any_req) begin
                        owner_reg <= dbg_win;
                        mem_we    <= dbg_win ? dbg_we    : cpu_we;
                        mem_addr  <= dbg_win ? dbg_addr  : cpu_addr;
                        mem_wdata <= dbg_win ? dbg_wdata : cpu_wdata;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        dbg_gnt   <= dbg_win;
                        state_reg <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_en       <= 1'b0;
                    wait_cnt_reg <= LAT_LOAD;
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_reg == 4'd0) begin
                        state_reg <= S_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    dbg_gnt   <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Per-requester completion pulse and read-data capture; index 0 is cpu, 1 is dbg.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic ID = (gi == 1);
            logic              done_reg;
            logic [DATA_W-1:0] rdata_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    done_reg  <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    done_reg <= last_wait && (owner_reg == ID);
                    if (last_wait && (owner_reg == ID) && !mem_we) begin
                        rdata_reg <= mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign cpu_done  = g_port[0].done_reg;
    assign cpu_rdata = g_port[0].rdata_reg;
    assign dbg_done  = g_port[1].done_reg;
    assign dbg_rdata = g_port[1].rdata_reg;
    assign cpu_stall = cpu_req & ~cpu_done;

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            dbg_grants   <= '0;
        end else begin
            if (cpu_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((state_reg == S_IDLE) && dbg_win && (dbg_grants != '1)) begin
                dbg_grants <= dbg_grants + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter (MEM_LAT=2, STARVE_MAX=4) with a two-stage memory model.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [63:0] cpu_addr = '0, cpu_wdata = '0;
    logic [63:0] cpu_rdata;
    logic        cpu_done, cpu_stall;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [63:0] dbg_addr = '0, dbg_wdata = '0;
    logic [63:0] dbg_rdata;
    logic        dbg_done, dbg_gnt;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] dbg_grants;
`endif

    int total = 0;
    int bad = 0;

    dmem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_done(dbg_done), .dbg_gnt(dbg_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_PERF_EN
        , .stall_cycles(stall_cycles), .dbg_grants(dbg_grants)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: read data valid two cycles after the mem_en cycle.
    logic [63:0] mem [0:31];
    logic [63:0] pipe1, pipe2;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:3]] <= mem_wdata;
            pipe1 <= mem[mem_addr[7:3]];
        end
        pipe2 <= pipe1;
    end
    assign mem_rdata = pipe2;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        total++; if ({cpu_done, dbg_done, dbg_gnt, cpu_stall} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {cpu_done, dbg_done, dbg_gnt, cpu_stall});
        end
        total++; if ((cpu_rdata !== 64'd0) || (dbg_rdata !== 64'd0)) begin
            bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", cpu_rdata, dbg_rdata);
        end
        total++; if ((mem_addr !== 64'd0) || (mem_we !== 1'b0)) begin
            bad++; $display("FAIL reset_mem_outs got=%h/%b exp=0/0", mem_addr, mem_we);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        $display("reset: checked idle outputs");
    endtask

    // One isolated access; cycle 0 is the IDLE cycle in which the request is first seen.
    task automatic run_access(input string name, input bit is_dbg, input bit we,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] exp_rdata);
        logic done_obs;
        for (int c = 0; c <= 4; c++) begin
            if (c == 0) begin
                if (is_dbg) begin
                    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
                end else begin
                    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
                end
            end else if (is_dbg) begin
                dbg_we = ~we; dbg_addr = ~addr; dbg_wdata = ~wdata;
            end else begin
                cpu_we = ~we; cpu_addr = ~addr; cpu_wdata = ~wdata;
            end
            #1;
            done_obs = is_dbg ? dbg_done : cpu_done;
            total++; if (mem_en !== (c == 1)) begin
                bad++; $display("FAIL %s mem_en cyc=%0d got=%b exp=%b", name, c, mem_en, (c == 1));
            end
            total++; if (busy !== (c >= 1)) begin
                bad++; $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, c, busy, (c >= 1));
            end
            total++; if (done_obs !== (c == 4)) begin
                bad++; $display("FAIL %s done cyc=%0d got=%b exp=%b", name, c, done_obs, (c == 4));
            end
            if (is_dbg) begin
                total++; if (dbg_gnt !== (c >= 1)) begin
                    bad++; $display("FAIL %s dbg_gnt cyc=%0d got=%b exp=%b", name, c, dbg_gnt, (c >= 1));
                end
            end else begin
                total++; if (cpu_stall !== (c <= 3)) begin
                    bad++; $display("FAIL %s cpu_stall cyc=%0d got=%b exp=%b", name, c, cpu_stall, (c <= 3));
                end
            end
            if (c == 1) begin
                total++; if ((mem_addr !== addr) || (mem_we !== we)) begin
                    bad++; $display("FAIL %s mem_cmd got=%h/%b exp=%h/%b", name, mem_addr, mem_we, addr, we);
                end
                if (we) begin
                    total++; if (mem_wdata !== wdata) begin
                        bad++; $display("FAIL %s mem_wdata got=%h exp=%h", name, mem_wdata, wdata);
                    end
                end
            end
            if (c == 4) begin
                if (is_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
            end
            tick();
        end
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_after got=%b exp=0", name, busy); end
        total++; if ((is_dbg ? dbg_rdata : cpu_rdata) !== exp_rdata) begin
            bad++; $display("FAIL %s rdata got=%h exp=%h", name, (is_dbg ? dbg_rdata : cpu_rdata), exp_rdata);
        end
        tick();
        $display("%s: %s %s addr=%h wdata=%h", name, is_dbg ? "dbg" : "cpu", we ? "write" : "read", addr, wdata);
    endtask

    task automatic test_dbg_write();
        run_access("dbg_write", 1'b1, 1'b1, 64'h10, 64'hDEAD_BEEF, 64'd0);
    endtask

    task automatic test_cpu_read();
        run_access("cpu_read", 1'b0, 1'b0, 64'h10, 64'h0, 64'hDEAD_BEEF);
    endtask

    task automatic test_cpu_write();
        run_access("cpu_write", 1'b0, 1'b1, 64'h8, 64'h55, 64'hDEAD_BEEF);
        run_access("cpu_readback", 1'b0, 1'b0, 64'h8, 64'h0, 64'h55);
    endtask

    task automatic test_starvation();
        bit order [10];
        int when [10];
        int n = 0;
        int cyc = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h8;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h10;
        while ((n < 10) && (cyc < 80)) begin
            #1;
            if (cpu_done || dbg_done) begin
                order[n] = dbg_done;
                when[n] = cyc;
                n++;
            end
            if (n == 10) begin cpu_req = 1'b0; dbg_req = 1'b0; end
            tick();
            cyc++;
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        total++; if (n != 10) begin bad++; $display("FAIL starve_count got=%0d exp=10", n); end
        for (int k = 0; k < n; k++) begin
            total++; if (order[k] !== ((k == 4) || (k == 9))) begin
                bad++; $display("FAIL starve_order idx=%0d got=%b exp=%b", k, order[k], ((k == 4) || (k == 9)));
            end
            total++; if (when[k] != 4 + 5 * k) begin
                bad++; $display("FAIL starve_timing idx=%0d got=%0d exp=%0d", k, when[k], 4 + 5 * k);
            end
        end
        #1;
        total++; if ((cpu_rdata !== 64'h55) || (dbg_rdata !== 64'hDEAD_BEEF)) begin
            bad++; $display("FAIL starve_rdata got=%h/%h exp=55/deadbeef", cpu_rdata, dbg_rdata);
        end
        tick();
        $display("starvation: %0d grants observed, dbg in slots 5 and 10 expected", n);
    endtask

    task automatic test_dbg_then_cpu();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h8;
        cpu_we = 1'b0; cpu_addr = 64'h10;
        for (int c = 0; c <= 9; c++) begin
            if (c == 2) cpu_req = 1'b1;
            if (c == 5) dbg_req = 1'b0;
            #1;
            total++; if (dbg_done !== (c == 4)) begin
                bad++; $display("FAIL dbg_cpu dbg_done cyc=%0d got=%b exp=%b", c, dbg_done, (c == 4));
            end
            total++; if (cpu_done !== (c == 9)) begin
                bad++; $display("FAIL dbg_cpu cpu_done cyc=%0d got=%b exp=%b", c, cpu_done, (c == 9));
            end
            total++; if (cpu_stall !== ((c >= 2) && (c <= 8))) begin
                bad++; $display("FAIL dbg_cpu cpu_stall cyc=%0d got=%b exp=%b", c, cpu_stall, ((c >= 2) && (c <= 8)));
            end
            total++; if (mem_en !== ((c == 1) || (c == 6))) begin
                bad++; $display("FAIL dbg_cpu mem_en cyc=%0d got=%b exp=%b", c, mem_en, ((c == 1) || (c == 6)));
            end
            if (c == 6) begin
                total++; if (mem_addr !== 64'h10) begin
                    bad++; $display("FAIL dbg_cpu mem_addr got=%h exp=10", mem_addr);
                end
            end
            if (c == 9) cpu_req = 1'b0;
            tick();
        end
        #1;
        total++; if ((dbg_rdata !== 64'h55) || (cpu_rdata !== 64'hDEAD_BEEF)) begin
            bad++; $display("FAIL dbg_cpu rdata got=%h/%h exp=55/deadbeef", dbg_rdata, cpu_rdata);
        end
        tick();
        $display("dbg_then_cpu: dbg read 0x8 then stalled cpu read 0x10");
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h8;
        tick();
        tick();
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid busy_before got=%b exp=1", busy); end
        reset = 1'b0;
        #1;
        total++; if ({busy, mem_en, cpu_done} !== 3'b000) begin
            bad++; $display("FAIL rst_mid drop got=%b exp=000", {busy, mem_en, cpu_done});
        end
        total++; if (cpu_rdata !== 64'd0) begin
            bad++; $display("FAIL rst_mid rdata_clr got=%h exp=0", cpu_rdata);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (cpu_done !== 1'b0) begin bad++; $display("FAIL rst_mid done_in_reset got=%b exp=0", cpu_done); end
        end
        reset = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            #1;
            total++; if (cpu_done !== (c == 4)) begin
                bad++; $display("FAIL rst_mid done cyc=%0d got=%b exp=%b", c, cpu_done, (c == 4));
            end
            total++; if (busy !== (c >= 1)) begin
                bad++; $display("FAIL rst_mid busy cyc=%0d got=%b exp=%b", c, busy, (c >= 1));
            end
            if (c == 4) cpu_req = 1'b0;
            tick();
        end
        #1;
        total++; if (cpu_rdata !== 64'h55) begin bad++; $display("FAIL rst_mid rdata got=%h exp=55", cpu_rdata); end
        tick();
        $display("reset_mid: reset in WAIT, access re-run after release");
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        total++; if ((stall_cycles !== 32'd0) || (dbg_grants !== 16'd0)) begin
            bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cycles, dbg_grants);
        end
        run_access("perf_cpu", 1'b0, 1'b0, 64'h10, 64'h0, 64'hDEAD_BEEF);
        run_access("perf_dbg", 1'b1, 1'b0, 64'h8, 64'h0, 64'h55);
        total++; if (stall_cycles !== 32'd4) begin bad++; $display("FAIL perf_stall got=%0d exp=4", stall_cycles); end
        total++; if (dbg_grants !== 16'd1) begin bad++; $display("FAIL perf_grants got=%0d exp=1", dbg_grants); end
        $display("perf: stall_cycles=%0d dbg_grants=%0d", stall_cycles, dbg_grants);
    endtask
`endif

    initial begin
        test_reset();
        test_dbg_write();
        test_cpu_read();
        test_cpu_write();
        test_starvation();
        test_dbg_then_cpu();
        test_reset_mid();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
